// File: rtl/xbar_pkt_switch.sv
// Packet-aware N x M crossbar with per-output round-robin arbitration.
// A grant is held from the first beat through the last beat of a packet.
// Optional per-output packet counters: define XBAR_PKT_CNT_EN.
module xbar_pkt_switch #(
    parameter int XBAR_INPUT     = 4,
    parameter int XBAR_INPUT_L2  = $clog2(XBAR_INPUT),
    parameter int XBAR_OUTPUT    = 4,
    parameter int XBAR_OUTPUT_L2 = (XBAR_OUTPUT > 1) ? $clog2(XBAR_OUTPUT) : 1,
    parameter int XBAR_WIDTH     = 8
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [XBAR_INPUT-1:0][XBAR_WIDTH-1:0]     in_data,
    input  logic [XBAR_INPUT-1:0][XBAR_OUTPUT_L2-1:0] in_dest,
    input  logic [XBAR_INPUT-1:0]                     in_valid,
    input  logic [XBAR_INPUT-1:0]                     in_last,
    output logic [XBAR_INPUT-1:0]                     in_ready,
    output logic [XBAR_OUTPUT-1:0][XBAR_WIDTH-1:0]    out_data,
    output logic [XBAR_OUTPUT-1:0]                    out_valid,
    output logic [XBAR_OUTPUT-1:0]                    out_last,
`ifdef XBAR_PKT_CNT_EN
    output logic [XBAR_OUTPUT-1:0][31:0]              out_pkt_cnt,
`endif
    input  logic [XBAR_OUTPUT-1:0]                    out_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e                   state_q  [XBAR_OUTPUT];
    state_e                   state_d  [XBAR_OUTPUT];
    logic [XBAR_INPUT_L2-1:0] grant_q  [XBAR_OUTPUT];
    logic [XBAR_INPUT_L2-1:0] grant_d  [XBAR_OUTPUT];
    logic [XBAR_INPUT_L2-1:0] rr_ptr_q [XBAR_OUTPUT];
    logic [XBAR_INPUT_L2-1:0] rr_ptr_d [XBAR_OUTPUT];

    logic [XBAR_INPUT-1:0]                  locked;
    logic [XBAR_OUTPUT-1:0][XBAR_INPUT-1:0] req;

    // First requester at or after ptr, searching cyclically upward.
    // Returns {found, index}.
    function automatic logic [XBAR_INPUT_L2:0] rr_pick(
        input logic [XBAR_INPUT-1:0]    r,
        input logic [XBAR_INPUT_L2-1:0] ptr
    );
        logic                     found;
        logic [XBAR_INPUT_L2-1:0] win;
        logic [XBAR_INPUT_L2-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < XBAR_INPUT; k++) begin
            idx = XBAR_INPUT_L2'((int'(ptr) + k) % XBAR_INPUT);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Inputs held by a locked output; only those may see ready.
    always_comb begin
        locked   = '0;
        in_ready = '0;
        for (int m = 0; m < XBAR_OUTPUT; m++) begin
            if (state_q[m] == ST_LOCK) begin
                locked[grant_q[m]]   = 1'b1;
                in_ready[grant_q[m]] = out_ready[m];
            end
        end
    end

    // Request matrix: a free, valid input asks only for its own destination.
    always_comb begin
        req = '0;
        for (int m = 0; m < XBAR_OUTPUT; m++) begin
            for (int i = 0; i < XBAR_INPUT; i++) begin
                req[m][i] = in_valid[i] && !locked[i] &&
                            (in_dest[i] == XBAR_OUTPUT_L2'(m));
            end
        end
    end

    // Per-output arbiter next state: grant in IDLE, release on last beat.
    always_comb begin
        logic [XBAR_INPUT_L2:0] pick;
        for (int m = 0; m < XBAR_OUTPUT; m++) begin
            state_d[m]  = state_q[m];
            grant_d[m]  = grant_q[m];
            rr_ptr_d[m] = rr_ptr_q[m];
            pick        = rr_pick(req[m], rr_ptr_q[m]);
            if (state_q[m] == ST_IDLE) begin
                if (pick[XBAR_INPUT_L2]) begin
                    grant_d[m] = pick[XBAR_INPUT_L2-1:0];
                    state_d[m] = ST_LOCK;
                end
            end else begin
                if (in_valid[grant_q[m]] && out_ready[m] &&
                    in_last[grant_q[m]]) begin
                    state_d[m]  = ST_IDLE;
                    rr_ptr_d[m] = (int'(grant_q[m]) == XBAR_INPUT - 1) ?
                                  '0 : grant_q[m] + 1'b1;
                end
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int m = 0; m < XBAR_OUTPUT; m++) begin
                state_q[m]  <= ST_IDLE;
                grant_q[m]  <= '0;
                rr_ptr_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < XBAR_OUTPUT; m++) begin
                state_q[m]  <= state_d[m];
                grant_q[m]  <= grant_d[m];
                rr_ptr_q[m] <= rr_ptr_d[m];
            end
        end
    end

    // Locked outputs pass the granted input straight through.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        out_last  = '0;
        for (int m = 0; m < XBAR_OUTPUT; m++) begin
            if (state_q[m] == ST_LOCK) begin
                out_data[m]  = in_data[grant_q[m]];
                out_valid[m] = in_valid[grant_q[m]];
                out_last[m]  = in_last[grant_q[m]];
            end
        end
    end

`ifdef XBAR_PKT_CNT_EN
    logic [31:0] cnt_q [XBAR_OUTPUT];
    logic [31:0] cnt_d [XBAR_OUTPUT];

    // Count accepted last beats; wraps naturally at 2^32.
    always_comb begin
        for (int m = 0; m < XBAR_OUTPUT; m++) begin
            cnt_d[m] = cnt_q[m] +
                       {31'd0, out_valid[m] & out_ready[m] & out_last[m]};
            out_pkt_cnt[m] = cnt_q[m];
        end
    end

    // Packet counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int m = 0; m < XBAR_OUTPUT; m++) begin
                cnt_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < XBAR_OUTPUT; m++) begin
                cnt_q[m] <= cnt_d[m];
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_pkt_switch.sv
// Self-checking bench for xbar_pkt_switch: queued input driver,
// per-output scoreboard, scenario tasks with inline timing checks.
module tb_xbar_pkt_switch;

    localparam int N = 4;
    localparam int M = 4;
    localparam int W = 8;

    logic                clk  = 1'b0;
    logic                rstn = 1'b0;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0][1:0]   in_dest;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_last;
    logic [N-1:0]        in_ready;
    logic [M-1:0][W-1:0] out_data;
    logic [M-1:0]        out_valid;
    logic [M-1:0]        out_last;
    logic [M-1:0]        out_ready;
`ifdef XBAR_PKT_CNT_EN
    logic [M-1:0][31:0]  out_pkt_cnt;
`endif

    typedef struct packed {
        logic [1:0] dest;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t      bq [N][$];
    logic [8:0] sb [M][$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    xbar_pkt_switch dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_data     (in_data),
        .in_dest     (in_dest),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
`ifdef XBAR_PKT_CNT_EN
        .out_pkt_cnt (out_pkt_cnt),
`endif
        .out_ready   (out_ready)
    );

    task automatic push_pkt(input int i, input int dest, input int n,
                            input int base, input int step);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.dest = 2'(dest);
            b.last = (k == n - 1);
            b.data = 8'(base + k * step);
            bq[i].push_back(b);
            sb[dest].push_back({b.last, b.data});
        end
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) bq[i].delete();
        for (int m = 0; m < M; m++) sb[m].delete();
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic driver();
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = rstn ? (in_valid & in_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && bq[i].size() > 0) void'(bq[i].pop_front());
                if (bq[i].size() > 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = bq[i][0].data;
                    in_dest[i]  = bq[i][0].dest;
                    in_last[i]  = bq[i][0].last;
                end else begin
                    in_valid[i] = 1'b0;
                    in_last[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic monitor();
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (rstn) begin
                for (int m = 0; m < M; m++) begin
                    if (out_valid[m] && out_ready[m]) begin
                        total++;
                        if (sb[m].size() == 0) begin
                            bad++;
                            $display("FAIL sb_extra out%0d got=%h required none",
                                     m, {out_last[m], out_data[m]});
                        end else begin
                            exp = sb[m].pop_front();
                            if ({out_last[m], out_data[m]} !== exp) begin
                                bad++;
                                $display("FAIL sb_beat out%0d got=%h required=%h",
                                         m, {out_last[m], out_data[m]}, exp);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_req(input int i);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_valid[i]) return;
        end
        total++;
        bad++;
        $display("FAIL req_timeout in%0d got=0 required=1", i);
    endtask

    task automatic wait_drain(input int m, input int budget);
        int c = 0;
        while (sb[m].size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (sb[m].size() != 0) begin
            bad++;
            $display("FAIL drain out%0d got=%0d left required=0", m, sb[m].size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total += 4;
        if (in_ready !== '0) begin
            bad++; $display("FAIL rst_in_ready got=%b required=0", in_ready);
        end
        if (out_valid !== '0) begin
            bad++; $display("FAIL rst_out_valid got=%b required=0", out_valid);
        end
        if (out_last !== '0) begin
            bad++; $display("FAIL rst_out_last got=%b required=0", out_last);
        end
        if (out_data !== '0) begin
            bad++; $display("FAIL rst_out_data got=%h required=0", out_data);
        end
        out_ready = '1;
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        @(negedge clk);
        push_pkt(0, 2, 3, 8'h11, 8'h11);
        wait_req(0);
        total++;
        if (out_valid[2] !== 1'b0) begin
            bad++; $display("FAIL single_bubble got=%b required=0", out_valid[2]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({out_valid[2], out_last[2], out_data[2]} !==
                {1'b1, (k == 2), exp_d[k]}) begin
                bad++;
                $display("FAIL single_beat%0d got=%b/%b/%h required=1/%b/%h", k,
                         out_valid[2], out_last[2], out_data[2], k == 2, exp_d[k]);
            end
        end
        @(negedge clk);
        total++;
        if (out_valid[2] !== 1'b0) begin
            bad++; $display("FAIL single_idle got=%b required=0", out_valid[2]);
        end
        wait_drain(2, 5);
    endtask

    task automatic test_rr();
        int ids [3];
        ids[0] = 0; ids[1] = 1; ids[2] = 3;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++) begin
                push_pkt(ids[j], 1, 1, 8'hA0 + r * 8'h10 + ids[j], 1);
            end
        end
        wait_req(0);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (out_valid[1] !== (c % 2 == 1)) begin
                bad++;
                $display("FAIL rr_cycle%0d got=%b required=%b", c,
                         out_valid[1], c % 2 == 1);
            end
        end
        wait_drain(1, 5);
    endtask

    task automatic test_parallel();
        @(negedge clk);
        push_pkt(0, 2, 2, 8'hC0, 1);
        push_pkt(1, 0, 2, 8'hD0, 1);
        push_pkt(2, 3, 2, 8'hE0, 1);
        push_pkt(3, 1, 2, 8'hF0, 1);
        wait_req(0);
        total++;
        if (out_valid !== 4'h0) begin
            bad++; $display("FAIL par_arb got=%b required=0000", out_valid);
        end
        @(negedge clk);
        total++;
        if ({out_valid, out_last} !== 8'hF0) begin
            bad++; $display("FAIL par_beat0 got=%b/%b required=1111/0000",
                            out_valid, out_last);
        end
        @(negedge clk);
        total++;
        if ({out_valid, out_last} !== 8'hFF) begin
            bad++; $display("FAIL par_beat1 got=%b/%b required=1111/1111",
                            out_valid, out_last);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 4'h0) begin
            bad++; $display("FAIL par_idle got=%b required=0000", out_valid);
        end
        for (int m = 0; m < M; m++) wait_drain(m, 5);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        push_pkt(0, 2, 4, 8'h40, 1);
        wait_req(0);
        @(negedge clk);
        total++;
        if ({out_valid[2], out_data[2]} !== {1'b1, 8'h40}) begin
            bad++; $display("FAIL bp_first got=%b/%h required=1/40",
                            out_valid[2], out_data[2]);
        end
        push_pkt(1, 2, 1, 8'h55, 1);
        @(posedge clk);
        #1 out_ready[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total += 3;
            if (in_ready[0] !== 1'b0) begin
                bad++; $display("FAIL bp_rdy0_c%0d got=%b required=0", c, in_ready[0]);
            end
            if (in_ready[1] !== 1'b0) begin
                bad++; $display("FAIL bp_rdy1_c%0d got=%b required=0", c, in_ready[1]);
            end
            if ({out_valid[2], out_data[2]} !== {1'b1, 8'h41}) begin
                bad++; $display("FAIL bp_hold_c%0d got=%b/%h required=1/41",
                                c, out_valid[2], out_data[2]);
            end
        end
        @(posedge clk);
        #1 out_ready[2] = 1'b1;
        wait_drain(2, 30);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        push_pkt(1, 0, 4, 8'h60, 1);
        wait_req(1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        total += 3;
        if ({out_valid, out_last} !== 8'h00) begin
            bad++; $display("FAIL rmid_valid got=%b/%b required=0/0", out_valid, out_last);
        end
        if (out_data !== '0) begin
            bad++; $display("FAIL rmid_data got=%h required=0", out_data);
        end
        if (in_ready !== '0) begin
            bad++; $display("FAIL rmid_ready got=%b required=0", in_ready);
        end
        flush();
        @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        push_pkt(3, 0, 2, 8'h70, 1);
        wait_req(3);
        total++;
        if (out_valid[0] !== 1'b0) begin
            bad++; $display("FAIL rpost_arb got=%b required=0", out_valid[0]);
        end
        @(negedge clk);
        total++;
        if ({out_valid[0], out_data[0]} !== {1'b1, 8'h70}) begin
            bad++; $display("FAIL rpost_beat got=%b/%h required=1/70",
                            out_valid[0], out_data[0]);
        end
        wait_drain(0, 5);
    endtask

`ifdef XBAR_PKT_CNT_EN
    task automatic test_pkt_cnt();
        @(negedge clk);
        rstn = 1'b0;
        flush();
        @(negedge clk);
        total++;
        if (out_pkt_cnt !== '0) begin
            bad++; $display("FAIL cnt_rst got=%h required=0", out_pkt_cnt);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10; k++) push_pkt(2, 1, 1, 8'h80 + k, 1);
        wait_drain(1, 60);
        @(negedge clk);
        total += 2;
        if (out_pkt_cnt[1] !== 32'd10) begin
            bad++; $display("FAIL cnt_ten got=%0d required=10", out_pkt_cnt[1]);
        end
        if ({out_pkt_cnt[0], out_pkt_cnt[2], out_pkt_cnt[3]} !== '0) begin
            bad++; $display("FAIL cnt_others got=%0d/%0d/%0d required=0",
                            out_pkt_cnt[0], out_pkt_cnt[2], out_pkt_cnt[3]);
        end
        dut.cnt_q[1] = 32'hFFFF_FFFF;
        push_pkt(2, 1, 1, 8'h9A, 1);
        wait_drain(1, 10);
        @(negedge clk);
        total++;
        if (out_pkt_cnt[1] !== 32'd0) begin
            bad++; $display("FAIL cnt_wrap got=%h required=0", out_pkt_cnt[1]);
        end
    endtask
`endif

    initial begin
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        in_dest   = '0;
        out_ready = '0;
        fork
            driver();
            monitor();
        join_none
        test_reset();
        test_single();
        test_rr();
        test_parallel();
        test_backpressure();
        test_reset_mid();
`ifdef XBAR_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbar_pkt_switch.md
Name: xbar_pkt_switch

Overview:
- Packet-aware N-input by M-output crossbar for the switch datapath.
- Successor to the combinational select-per-output crossbar.
- Adds a valid/ready handshake per port, per-output round-robin arbitration, and grant locking for the whole packet (first beat through last beat).
- Sits between the ingress queues and the egress port FIFOs.

Parameters:
- XBAR_INPUT, 4, number of input channels N (2..16).
- XBAR_INPUT_L2, $clog2(XBAR_INPUT), input index width.
- XBAR_OUTPUT, 4, number of output channels M (1..16).
- XBAR_OUTPUT_L2, $clog2(XBAR_OUTPUT) (minimum 1), destination index width.
- XBAR_WIDTH, 8, data beat width in bits.

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- rstn, input, 1, asynchronous active-low reset.
- in_data, input, [XBAR_WIDTH-1:0] x N, input beat data.
- in_dest, input, [XBAR_OUTPUT_L2-1:0] x N, destination output; held stable for the whole packet.
- in_valid, input, N, beat valid.
- in_last, input, N, final beat of the packet.
- in_ready, output, N, beat accepted when valid && ready.
- out_data, output, [XBAR_WIDTH-1:0] x M, output beat data.
- out_valid, output, M, output beat valid.
- out_last, output, M, final beat of the packet.
- out_ready, input, M, downstream accept.

Behaviour:
- Reset (asynchronous, rstn=0):
  - All arbiters go to IDLE.
  - rr_ptr[m] = 0 and grant[m] = 0.
  - in_ready = 0, out_valid = 0, out_last = 0, out_data = 0.
- Request: input i requests output m when in_valid[i] && in_dest[i]==m && input i is not locked to any output. An out-of-range in_dest (>= M) is never granted; that input stalls.
- Per-output FSM, IDLE state:
  - out_valid[m] = 0.
  - If any request exists, pick the first requester at or after rr_ptr[m], searching cyclically upward.
  - Register that winner into grant[m]; next state is LOCK.
  - No beat transfers in the arbitration cycle, so each packet costs 1 bubble cycle.
- Per-output FSM, LOCK state:
  - Output side: out_data[m] = in_data[g], out_valid[m] = in_valid[g], out_last[m] = in_last[g]. This path is combinational, so there is zero beat latency once locked.
  - Input side: in_ready[g] = out_ready[m].
  - When in_valid[g] && out_ready[m] && in_last[g]: next state is IDLE and rr_ptr[m] = (g+1) mod N.
  - A gap in in_valid[g] mid-packet holds the lock.
- Input lock: an input is locked by at most one output. in_ready[i] = 0 whenever input i holds no grant.
- Simultaneous events:
  - Several outputs in IDLE may each grant different inputs in the same cycle.
  - An input requests only its own in_dest, so there is no double grant.
  - A last-beat release and a new request on the same output in the same cycle: the new request is arbitrated in the following cycle, which is IDLE.
- Single-beat packet (first beat also has last=1): 1 arbitration cycle plus 1 transfer cycle, then IDLE.
- Fairness: with K continuous requesters, each is granted within K packets.
- Reset mid-packet: the packet is dropped by the switch (the lock is lost). Upstream restarts from the first beat after reset.

Optional Feature:
- Macro: XBAR_PKT_CNT_EN.
- When defined:
  - Adds output out_pkt_cnt, [31:0] x M.
  - Counter m increments on each accepted out_last beat of output m.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset value is 0.
- When undefined: the port and its counters are absent. Datapath behaviour is identical either way.

Test Plan:
- Reset, then input 0 sends a 3-beat packet to output 2 (data 0x11, 0x22, 0x33), with out_ready=1:
  - out_valid[2] rises 1 cycle after the request.
  - Beats appear on consecutive cycles and out_last is high on 0x33.
  - The FSM returns to IDLE.
- Inputs 0, 1, 3 each send continuous 1-beat packets to output 1:
  - Grant order is 0, 1, 3, 0, 1, 3.
  - Every packet takes 2 cycles.
- Inputs 0→2, 1→0, 2→3, 3→1 all start in the same cycle: all four outputs lock in parallel with no stall, and out_data matches its source.
- Output 2 locked to input 0; out_ready[2] held 0 for 5 cycles mid-packet:
  - in_ready[0] = 0 for those cycles.
  - out_data is held and no beat is lost or duplicated.
  - Input 1 requesting output 2 waits until after last.
- rstn asserted during beat 2 of 4: all outputs go to 0 immediately. After release, a new packet from input 3 wins output 0 with rr_ptr=0.
- With XBAR_PKT_CNT_EN, 10 packets to output 1: out_pkt_cnt[1] = 10 and the other counters = 0. A counter preloaded to 0xFFFFFFFF wraps to 0 after one more packet.
